// File: rtl/ddr_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_frame_reader_if
//  Brief    : AXI read-channel and output-FIFO write bundle for the frame reader
//  Revision : 1.0 - initial release
// ============================================================================
interface ddr_frame_reader_if #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 256
);
    logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
    logic [3:0]                 axi_arlen;
    logic                       axi_arvalid;
    logic                       axi_arready;
    logic [DATA_WIDTH-1:0]      axi_rdata;
    logic                       axi_rvalid;
    logic                       axi_rlast;
    logic                       fifo_afull;
    logic                       fifo_wen;
    logic [DATA_WIDTH-1:0]      fifo_wdata;

    modport master (
        output axi_araddr, axi_arlen, axi_arvalid,
        input  axi_arready, axi_rdata, axi_rvalid, axi_rlast,
        input  fifo_afull,
        output fifo_wen, fifo_wdata
    );

    modport slave (
        input  axi_araddr, axi_arlen, axi_arvalid,
        output axi_arready, axi_rdata, axi_rvalid, axi_rlast,
        output fifo_afull,
        input  fifo_wen, fifo_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ddr_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_frame_reader
//  Brief    : AXI read master streaming a stored frame from DDR to the output FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_frame_reader #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 32,
    parameter logic [CTRL_ADDR_WIDTH-1:0] AXI_RADDR_BASE  = '0,
    parameter int                         FRAME_BURSTS    = 16200,
    parameter int                         BEAT_ADDR_INC   = 8
) (
    input  wire                core_clk,
    input  wire                ddr_rst,
    input  wire                ddr_init_done,
    input  wire                frame_start,
    output logic               frame_done,
    output logic               rd_err,
    ddr_frame_reader_if.master bus
);
    localparam int c_data_w = MEM_DQ_WIDTH * 8;
    localparam int c_idx_w  = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [c_idx_w-1:0]         c_last_idx   = c_idx_w'(FRAME_BURSTS - 1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] c_burst_step = CTRL_ADDR_WIDTH'(16 * BEAT_ADDR_INC);

    typedef enum logic [4:0] {
        S_IDLE       = 5'b00001,
        S_WAIT_FRAME = 5'b00010,
        S_CHECK      = 5'b00100,
        S_RD_ADDR    = 5'b01000,
        S_RD_DATA    = 5'b10000
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [c_idx_w-1:0]         r_burst_idx, w_burst_idx_nxt;
    logic [3:0]                 r_beat_cnt, w_beat_cnt_nxt;
    logic                       r_restart_pend, w_restart_pend_nxt;
    logic                       r_arvalid, w_arvalid_nxt;
    logic [CTRL_ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
    logic [3:0]                 r_arlen, w_arlen_nxt;
    logic                       r_frame_done, w_frame_done_nxt;
    logic                       r_rd_err, w_rd_err_nxt;
    logic                       r_fifo_wen;
    logic [c_data_w-1:0]        r_fifo_wdata;

    logic                       w_in_data;
    logic [c_idx_w-1:0]         w_idx_eff;

    assign w_in_data = (r_state == S_RD_DATA);
    // A frame_start seen in S_CHECK rewinds the very burst about to be issued
    assign w_idx_eff = frame_start ? '0 : r_burst_idx;

    always_comb begin
        w_state_nxt        = r_state;
        w_burst_idx_nxt    = r_burst_idx;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_restart_pend_nxt = r_restart_pend;
        w_arvalid_nxt      = r_arvalid;
        w_araddr_nxt       = r_araddr;
        w_arlen_nxt        = r_arlen;
        w_frame_done_nxt   = 1'b0;
        w_rd_err_nxt       = r_rd_err;

        if (bus.axi_rvalid && !w_in_data) begin
            w_rd_err_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (ddr_init_done) begin
                    w_state_nxt = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_start) begin
                    w_burst_idx_nxt = '0;
                    w_state_nxt     = S_CHECK;
                end
            end
            S_CHECK: begin
                w_burst_idx_nxt = w_idx_eff;
                if (!bus.fifo_afull) begin
                    w_arvalid_nxt = 1'b1;
                    w_araddr_nxt  = AXI_RADDR_BASE + CTRL_ADDR_WIDTH'(w_idx_eff) * c_burst_step;
                    w_arlen_nxt   = 4'hf;
                    w_state_nxt   = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (frame_start) begin
                    w_restart_pend_nxt = 1'b1;
                end
                if (r_arvalid && bus.axi_arready) begin
                    w_arvalid_nxt  = 1'b0;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (frame_start) begin
                    w_restart_pend_nxt = 1'b1;
                end
                if (bus.axi_rvalid) begin
                    if (bus.axi_rlast) begin
                        if (r_beat_cnt != 4'd15) begin
                            w_rd_err_nxt = 1'b1;
                        end
                        w_beat_cnt_nxt = '0;
                        // Restart beats frame completion when both land together
                        if (r_restart_pend || frame_start) begin
                            w_burst_idx_nxt    = '0;
                            w_restart_pend_nxt = 1'b0;
                            w_state_nxt        = S_CHECK;
                        end else if (r_burst_idx == c_last_idx) begin
                            w_frame_done_nxt = 1'b1;
                            w_burst_idx_nxt  = '0;
                            w_state_nxt      = S_WAIT_FRAME;
                        end else begin
                            w_burst_idx_nxt = r_burst_idx + c_idx_w'(1);
                            w_state_nxt     = S_CHECK;
                        end
                    end else if (r_beat_cnt == 4'd15) begin
                        w_rd_err_nxt = 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_state        <= S_IDLE;
            r_burst_idx    <= '0;
            r_beat_cnt     <= '0;
            r_restart_pend <= 1'b0;
            r_arvalid      <= 1'b0;
            r_araddr       <= '0;
            r_arlen        <= '0;
            r_frame_done   <= 1'b0;
            r_rd_err       <= 1'b0;
            r_fifo_wen     <= 1'b0;
            r_fifo_wdata   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_burst_idx    <= w_burst_idx_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_restart_pend <= w_restart_pend_nxt;
            r_arvalid      <= w_arvalid_nxt;
            r_araddr       <= w_araddr_nxt;
            r_arlen        <= w_arlen_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_rd_err       <= w_rd_err_nxt;
            r_fifo_wen     <= bus.axi_rvalid && w_in_data;
            r_fifo_wdata   <= bus.axi_rdata;
        end
    end

    assign bus.axi_arvalid = r_arvalid;
    assign bus.axi_araddr  = r_araddr;
    assign bus.axi_arlen   = r_arlen;
    assign bus.fifo_wen    = r_fifo_wen;
    assign bus.fifo_wdata  = r_fifo_wdata;
    assign frame_done      = r_frame_done;
    assign rd_err          = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_frame_reader
//  Brief    : Self-checking bench for ddr_frame_reader with a burst-level model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_frame_reader;
    localparam int             AW   = 28;
    localparam int             DQ   = 32;
    localparam int             DW   = DQ * 8;
    localparam int             FB   = 4;
    localparam int             INC  = 8;
    localparam logic [AW-1:0]  BASE = '0;

    logic core_clk = 1'b0;
    logic ddr_rst  = 1'b1;
    logic ddr_init_done = 1'b0;
    logic frame_start = 1'b0;
    logic frame_done;
    logic rd_err;

    ddr_frame_reader_if #(.CTRL_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ddr_frame_reader #(
        .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .AXI_RADDR_BASE(BASE),
        .FRAME_BURSTS(FB), .BEAT_ADDR_INC(INC)
    ) dut (
        .core_clk(core_clk), .ddr_rst(ddr_rst), .ddr_init_done(ddr_init_done),
        .frame_start(frame_start), .frame_done(frame_done), .rd_err(rd_err), .bus(bus)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;
    int m_idx  = 0;   // burst index the model expects next
    bit m_done = 1'b0;

    typedef struct {
        int            ar_delay;
        int            afull_cyc;
        int            fs_phase;   // 0 none, 1 during AR, 2 mid-burst, 3 with rlast
        bit            fs_in_check;
        logic [AW-1:0] exp_addr;
        bit            exp_done;
    } vec_t;
    vec_t tbl[15];

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic chk1(input string name, input logic act, input logic exp);
        chkw(name, DW'(act), DW'(exp));
    endtask
    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        chkw(name, DW'(act), DW'(exp));
    endtask

    task automatic tick;
        @(posedge core_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] m_addr();
        return BASE + AW'(m_idx * 16 * INC);
    endfunction

    task automatic m_finish_burst(input bit restart, output bit done);
        done = 1'b0;
        if (restart) m_idx = 0;
        else if (m_idx == FB - 1) begin
            done  = 1'b1;
            m_idx = 0;
        end else m_idx++;
    endtask

    task automatic do_reset;
        ddr_rst = 1'b1;
        frame_start = 1'b0;
        ddr_init_done = 1'b0;
        bus.axi_arready = 1'b0;
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast = 1'b0;
        bus.axi_rdata = '0;
        bus.fifo_afull = 1'b0;
        repeat (2) @(posedge core_clk);
        #1 ddr_rst = 1'b0;
        m_idx = 0;
        tick;
    endtask

    task automatic init_and_frame;
        ddr_init_done = 1'b1;
        tick;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        m_idx = 0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit last);
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = d;
        bus.axi_rlast  = last;
        tick;
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        frame_start    = 1'b0;
        chk1("fifo_wen", bus.fifo_wen, 1'b1);
        chkw("fifo_wdata", bus.fifo_wdata, d);
    endtask

    task automatic issue_ar;
        tick;
        chk1("ar_issue", bus.axi_arvalid, 1'b1);
        bus.axi_arready = 1'b1;
        tick;
        bus.axi_arready = 1'b0;
    endtask

    task automatic run_burst(input int ar_delay, input int afull_cyc, input int fs_phase,
                             input int gap_max, input bit fs_in_check, input bit pat,
                             output logic [AW-1:0] act_addr, output logic act_done);
        logic [DW-1:0] d;
        bit exp_done;
        if (afull_cyc > 0) begin
            bus.fifo_afull = 1'b1;
            for (int c = 0; c < afull_cyc; c++) begin
                frame_start = fs_in_check && (c == 0);
                tick;
                if (frame_start) m_idx = 0;
                frame_start = 1'b0;
                chk1("afull_no_ar", bus.axi_arvalid, 1'b0);
            end
            bus.fifo_afull = 1'b0;
        end
        tick;
        chk1("ar_issue", bus.axi_arvalid, 1'b1);
        chkw("arlen", DW'(bus.axi_arlen), DW'(4'hf));
        act_addr = bus.axi_araddr;
        chka("araddr_model", act_addr, m_addr());
        for (int c = 0; c < ar_delay; c++) begin
            frame_start = (fs_phase == 1) && (c == 0);
            tick;
            frame_start = 1'b0;
            chk1("ar_hold_valid", bus.axi_arvalid, 1'b1);
            chka("ar_hold_addr", bus.axi_araddr, act_addr);
        end
        bus.axi_arready = 1'b1;
        frame_start = (fs_phase == 1) && (ar_delay == 0);
        tick;
        bus.axi_arready = 1'b0;
        frame_start = 1'b0;
        chk1("ar_drop", bus.axi_arvalid, 1'b0);
        for (int i = 0; i < 16; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                tick;
                chk1("wen_idle", bus.fifo_wen, 1'b0);
            end
            d = pat ? DW'(i) : rnd();
            frame_start = ((fs_phase == 2) && (i == 7)) || ((fs_phase == 3) && (i == 15));
            send_beat(d, i == 15);
        end
        m_finish_burst(fs_phase != 0, exp_done);
        act_done = frame_done;
        chk1("frame_done_model", act_done, exp_done);
        m_done = exp_done;
    endtask

    task automatic after_done;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk1("idle_no_ar", bus.axi_arvalid, 1'b0);
            chk1("done_pulse", frame_done, 1'b0);
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        m_idx = 0;
        m_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic dn;

        tbl[0]  = '{0, 0, 0, 0, 28'd0,   1'b0};
        tbl[1]  = '{5, 0, 0, 0, 28'd128, 1'b0};
        tbl[2]  = '{0, 20, 0, 0, 28'd256, 1'b0};
        tbl[3]  = '{1, 0, 0, 0, 28'd384, 1'b1};
        tbl[4]  = '{0, 0, 0, 0, 28'd0,   1'b0};
        tbl[5]  = '{2, 0, 2, 0, 28'd128, 1'b0};
        tbl[6]  = '{0, 0, 0, 0, 28'd0,   1'b0};
        tbl[7]  = '{3, 0, 1, 0, 28'd128, 1'b0};
        tbl[8]  = '{0, 0, 0, 0, 28'd0,   1'b0};
        tbl[9]  = '{0, 0, 0, 0, 28'd128, 1'b0};
        tbl[10] = '{0, 0, 0, 0, 28'd256, 1'b0};
        tbl[11] = '{0, 0, 3, 0, 28'd384, 1'b0};
        tbl[12] = '{0, 0, 0, 0, 28'd0,   1'b0};
        tbl[13] = '{0, 4, 0, 1, 28'd0,   1'b0};
        tbl[14] = '{0, 0, 0, 0, 28'd128, 1'b0};

        do_reset;
        chk1("rst_arvalid", bus.axi_arvalid, 1'b0);
        chka("rst_araddr", bus.axi_araddr, '0);
        chkw("rst_arlen", DW'(bus.axi_arlen), '0);
        chk1("rst_wen", bus.fifo_wen, 1'b0);
        chkw("rst_wdata", bus.fifo_wdata, '0);
        chk1("rst_done", frame_done, 1'b0);
        chk1("rst_err", rd_err, 1'b0);

        ddr_init_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            chk1("no_ar_before_frame", bus.axi_arvalid, 1'b0);
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        m_idx = 0;

        for (int r = 0; r < 15; r++) begin
            run_burst(tbl[r].ar_delay, tbl[r].afull_cyc, tbl[r].fs_phase, r % 3,
                      tbl[r].fs_in_check, 1'b1, a, dn);
            chka("tbl_addr", a, tbl[r].exp_addr);
            chk1("tbl_done", dn, tbl[r].exp_done);
            if (m_done) after_done;
        end

        for (int r = 0; r < 30; r++) begin
            int ad, af, fsp, gp;
            bit fic;
            ad  = int'($urandom_range(3, 0));
            af  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 2)) : 0;
            fsp = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            fic = (af > 0) && ($urandom_range(3, 0) == 0);
            gp  = int'($urandom_range(2, 0));
            run_burst(ad, af, fsp, gp, fic, 1'b0, a, dn);
            if (m_done) after_done;
        end
        chk1("no_err_clean_run", rd_err, 1'b0);

        // Short burst: rlast on beat 10 flags a sticky error, burst still counts
        do_reset;
        init_and_frame;
        issue_ar;
        for (int i = 0; i < 11; i++) send_beat(DW'(i), i == 10);
        chk1("short_burst_err", rd_err, 1'b1);
        m_finish_burst(1'b0, m_done);
        run_burst(0, 0, 0, 0, 1'b0, 1'b1, a, dn);
        chk1("err_sticky", rd_err, 1'b1);

        // Stray beat outside a burst
        do_reset;
        ddr_init_done = 1'b1;
        tick;
        bus.axi_rvalid = 1'b1;
        tick;
        bus.axi_rvalid = 1'b0;
        chk1("stray_no_wen", bus.fifo_wen, 1'b0);
        chk1("stray_err", rd_err, 1'b1);

        // Missing rlast: error on the 16th beat, FSM keeps waiting for rlast
        do_reset;
        init_and_frame;
        issue_ar;
        for (int i = 0; i < 18; i++) begin
            send_beat(rnd(), 1'b0);
            if (i == 14) chk1("no_err_15_beats", rd_err, 1'b0);
            if (i == 15) chk1("missing_rlast_err", rd_err, 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            chk1("wait_rlast_no_ar", bus.axi_arvalid, 1'b0);
        end
        send_beat(rnd(), 1'b1);
        m_finish_burst(1'b0, m_done);
        tick;
        chk1("after_late_rlast_ar", bus.axi_arvalid, 1'b1);
        chka("after_late_rlast_addr", bus.axi_araddr, m_addr());

        // Asynchronous reset in the middle of a burst
        do_reset;
        init_and_frame;
        issue_ar;
        for (int i = 0; i < 3; i++) send_beat(DW'(i + 100), 1'b0);
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = DW'(55);
        tick;
        chk1("pre_rst_wen", bus.fifo_wen, 1'b1);
        #2 ddr_rst = 1'b1;
        bus.axi_rvalid = 1'b0;
        #1;
        chk1("async_rst_wen", bus.fifo_wen, 1'b0);
        chkw("async_rst_wdata", bus.fifo_wdata, '0);
        ddr_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk1("post_rst_no_ar", bus.axi_arvalid, 1'b0);
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        chk1("post_rst_ar", bus.axi_arvalid, 1'b1);
        chka("post_rst_addr", bus.axi_araddr, BASE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
